// File: rtl/branch_ctrl.sv
// -----------------------------------------------------------------------------
// branch_ctrl
//
// Branch prediction and redirect controller for the 5-stage pipeline.
//   - Fetch side: a bimodal table of 2-bit saturating counters, indexed by
//     PC word address, gives a registered taken/not-taken prediction.
//   - Execute side: the resolved outcome is compared with the prediction that
//     travelled down the pipe. The matching counter is trained, and on a
//     mispredict a one-shot IF flush plus a PC redirect is raised. The
//     redirect is held until the pipeline is no longer stalled.
//
// Build option:
//   BRANCH_PRED_EN defined   -> bimodal history table present.
//   BRANCH_PRED_EN undefined -> static not-taken. There is no table storage.
//                               PredTaken is constant 0, every taken branch
//                               redirects to ExTarget, and the redirect
//                               handshake is unchanged.
//
// Parameters:
//   BHT_ENTRIES  number of 2-bit counters (power of two, >= 2)
//   ADDR_W       PC / target width
//
// Ports:
//   CLK            clock, rising edge
//   nRST           synchronous active-low reset
//   IfValid        fetch stage holds a valid PC
//   IfPC           fetch PC
//   PredTaken      registered prediction for IfPC (valid in ID)
//   ExBranch       execute stage holds a conditional branch
//   ExPC           PC of that branch
//   ExTarget       computed taken target
//   ExPredTaken    prediction carried down with the branch
//   Taken          resolved branch outcome
//   Stall          pipeline stalled, no stage advances
//   Flush          kill the IF-stage instruction (one cycle per redirect)
//   RedirectValid  RedirectPC must be loaded into the PC
//   RedirectPC     corrected fetch address
// -----------------------------------------------------------------------------
module branch_ctrl #(
   parameter int BHT_ENTRIES = 64,
   parameter int ADDR_W      = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              IfValid,
   input  logic [ADDR_W-1:0] IfPC,
   output logic              PredTaken,
   input  logic              ExBranch,
   input  logic [ADDR_W-1:0] ExPC,
   input  logic [ADDR_W-1:0] ExTarget,
   input  logic              ExPredTaken,
   input  logic              Taken,
   input  logic              Stall,
   output logic              Flush,
   output logic              RedirectValid,
   output logic [ADDR_W-1:0] RedirectPC
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   typedef enum logic {
      IDLE  = 1'b0,
      REDIR = 1'b1
   } stateT;

   stateT             stateReg, stateNext;
   logic              flushNext;
   logic              redirValidNext;
   logic [ADDR_W-1:0] redirPcNext;

   logic              resolveEvt;
   logic              mispredict;
   logic [ADDR_W-1:0] redirTarget;

   // A branch is resolved only when the pipe advances and no redirect is
   // already in flight. While REDIR is active, the branch in EX is on the
   // wrong path and must not be allowed to train the table.
   assign resolveEvt = ExBranch & ~Stall & (stateReg == IDLE);

`ifdef BRANCH_PRED_EN
   logic [IDX_W-1:0]       ifIdx;
   logic [IDX_W-1:0]       exIdx;
   logic [BHT_ENTRIES-1:0] ctrMsb;
   logic                   unusedIfPcBits;

   assign ifIdx = IfPC[IDX_W+1:2];
   assign exIdx = ExPC[IDX_W+1:2];

   assign unusedIfPcBits = ^{IfPC[ADDR_W-1:IDX_W+2], IfPC[1:0]};

   // One saturating counter per entry. It resets to weakly not-taken.
   for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : bhtGen
      logic [1:0] ctrReg;

      always_ff @(posedge CLK) begin
         if (!nRST) begin
            ctrReg <= 2'b01;
         end else if (resolveEvt && (exIdx == IDX_W'(gi))) begin
            if (Taken && (ctrReg != 2'b11)) begin
               ctrReg <= ctrReg + 2'd1;
            end else if (!Taken && (ctrReg != 2'b00)) begin
               ctrReg <= ctrReg - 2'd1;
            end
         end
      end

      assign ctrMsb[gi] = ctrReg[1];
   end

   // The table read uses the counter values from before this edge, so a
   // same-cycle train of the same entry is not bypassed.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         PredTaken <= 1'b0;
      end else if (!Stall) begin
         PredTaken <= IfValid & ctrMsb[ifIdx];
      end
   end

   assign mispredict  = resolveEvt & (Taken != ExPredTaken);
   // The not-taken fall-through skips the delay slot.
   assign redirTarget = Taken ? ExTarget : (ExPC + ADDR_W'(8));
`else
   logic unusedStaticInputs;

   assign unusedStaticInputs = ^{IfValid, IfPC, ExPC, ExPredTaken};

   assign PredTaken   = 1'b0;
   assign mispredict  = resolveEvt & Taken;
   assign redirTarget = ExTarget;
`endif

   // Redirect sequencer. All outputs are registered. Flush is high only in
   // the first REDIR cycle. RedirectValid and RedirectPC are held until
   // the pipeline advances.
   always_comb begin
      stateNext      = stateReg;
      flushNext      = 1'b0;
      redirValidNext = 1'b0;
      redirPcNext    = '0;
      unique case (stateReg)
         IDLE: begin
            if (mispredict) begin
               stateNext      = REDIR;
               flushNext      = 1'b1;
               redirValidNext = 1'b1;
               redirPcNext    = redirTarget;
            end
         end
         REDIR: begin
            if (Stall) begin
               redirValidNext = 1'b1;
               redirPcNext    = RedirectPC;
            end else begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         stateReg      <= IDLE;
         Flush         <= 1'b0;
         RedirectValid <= 1'b0;
         RedirectPC    <= '0;
      end else begin
         stateReg      <= stateNext;
         Flush         <= flushNext;
         RedirectValid <= redirValidNext;
         RedirectPC    <= redirPcNext;
      end
   end

endmodule
